// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg: opcodes, ALU op codes, FSM states and the control-word layout
package multi_cycle_control_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_JUMP
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/multi_cycle_control_decode.sv
// multi_cycle_control_decode: combinational state -> control-word table
module multi_cycle_control_decode
  import multi_cycle_control_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS main controller FSM with retired-instruction counter
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               opcode,
  input  logic                     memReady,
  output logic                     pcWrite,
  output logic                     pcWriteCond,
  output logic                     iorD,
  output logic                     memRead,
  output logic                     memWrite,
  output logic                     irWrite,
  output logic                     memToReg,
  output logic                     regDst,
  output logic                     regWrite,
  output logic                     aluSrcA,
  output logic [1:0]               aluSrcB,
  output logic [1:0]               aluOp,
  output logic [1:0]               pcSource,
  output logic                     illegalOp,
  output logic [INSTRET_WIDTH-1:0] instret
);
  state_t state, next;
  ctrl_t  ctrl;
  logic   retire;
  multi_cycle_control_decode u_decode (.state(state), .ctrl(ctrl));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= S_IDLE;
      instret <= '0;
    end else begin
      state <= next;
      if (retire) instret <= instret + INSTRET_WIDTH'(1);
    end
  always_comb begin
    next      = S_FETCH;
    retire    = 1'b0;
    illegalOp = 1'b0;
    case (state)
      S_IDLE:      next = S_FETCH;
      S_FETCH:     next = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next = S_R_EXEC;
          OP_LW, OP_SW: next = S_MEM_ADDR;
          OP_BEQ:       next = S_BRANCH;
          OP_J:         next = S_JUMP;
          OP_ADDI:      next = S_ADDI_EXEC;
          default:      illegalOp = 1'b1;
        endcase
      end
      S_MEM_ADDR:  next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        next   = memReady ? S_FETCH : S_MEM_WRITE;
        retire = memReady;
      end
      S_R_EXEC:    next = S_R_WB;
      S_ADDI_EXEC: next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      default:     next = S_FETCH;
    endcase
  end
  // FETCH's writes only land in the cycle memory actually returns the instruction
  assign pcWrite     = ctrl.pc_write & (state != S_FETCH || memReady);
  assign irWrite     = ctrl.ir_write & memReady;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign iorD        = ctrl.iord;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign memToReg    = ctrl.mem_to_reg;
  assign regDst      = ctrl.reg_dst;
  assign regWrite    = ctrl.reg_write;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign aluOp       = ctrl.alu_op;
  assign pcSource    = ctrl.pc_source;
endmodule
